div_frecventa_prog: RTL and testbench

DIV_FRECVENTA_PROG -- requirements
Module: div_frecventa_prog

---
 rtl/div_pkg.sv | 18 +
 rtl/div_channel.sv | 120 ++++++++++++
 rtl/div_frecventa_prog.sv | 44 ++++
 tb/tb_div_frecventa_prog.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the programmable frequency divider.
//   ch_state_t : per-channel state (IDLE, RUN_PER, RUN_ONE)
//   MODE_PER / MODE_ONE : values of a channel's mode input
//   DEF_CNT_W  : default counter / divide-value width
package div_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN_PER = 2'd1,
    RUN_ONE = 2'd2
  } ch_state_t;

  localparam logic MODE_PER = 1'b0;
  localparam logic MODE_ONE = 1'b1;

  localparam int DEF_CNT_W = 24;

endpackage

// File: rtl/div_channel.sv
// One divider channel: divide register, counter, state and registered tick.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable        : count enable (0 forces IDLE)
//   mode          : 0 = periodic, 1 = one-shot (sampled only in IDLE)
//   start         : one-shot arm / re-arm pulse
//   load, div_val : divide-value write strobe and value (0 is stored as 1)
//   tick          : registered one-cycle pulse on each terminal count
//   busy          : channel is in RUN_PER or RUN_ONE
module div_channel
  import div_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             tick,
  output logic             busy
);

  ch_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic             tick_reg, tick_next;

  logic [CNT_W-1:0] term;
  logic [CNT_W-1:0] cnt_inc;
  logic             hit;
  logic             first_hit;

  // The counter runs 0 .. div_reg-1. tick is registered on the edge where the
  // counter arrives at div_reg-1, so the pulse is high exactly during the
  // cycle the counter holds its terminal value; the counter wraps to 0 on the
  // following edge. The edge that leaves IDLE (or a load / re-arm) places the
  // counter at 0, which makes a divide value of N tick every N cycles and a
  // divide value of 1 tick on every cycle.
  assign term      = div_reg - CNT_W'(1);
  assign cnt_inc   = (cnt_reg == term) ? '0 : cnt_reg + CNT_W'(1);
  assign hit       = (cnt_inc == term);
  assign first_hit = (div_reg == CNT_W'(1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    div_next   = div_reg;
    tick_next  = 1'b0;

    if (load) begin
      // A write restarts the phase and suppresses any tick due this cycle.
      div_next = (div_val == '0) ? CNT_W'(1) : div_val;
      cnt_next = '0;
      if (!enable) begin
        state_next = IDLE;
      end
    end else if (!enable) begin
      state_next = IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_next = '0;
          if (mode == MODE_PER) begin
            state_next = RUN_PER;
            tick_next  = first_hit;
          end else if (start) begin
            // With a divide of 1 the single one-shot tick is due at once,
            // so the channel never becomes busy.
            tick_next = first_hit;
            if (!first_hit) begin
              state_next = RUN_ONE;
            end
          end
        end
        RUN_PER: begin
          cnt_next  = cnt_inc;
          tick_next = hit;
        end
        RUN_ONE: begin
          if (start) begin
            cnt_next = '0;
          end else if (hit) begin
            tick_next  = 1'b1;
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      div_reg   <= CNT_W'(DEFAULT_DIV);
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      div_reg   <= div_next;
      tick_reg  <= tick_next;
    end
  end

  assign tick = tick_reg;
  assign busy = (state_reg != IDLE);

endmodule

// File: rtl/div_frecventa_prog.sv
// Multi-channel programmable frequency divider. Each channel is an
// independent div_channel; the top only slices the packed divide values.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   enable, mode, start, load : per-channel controls (bit i = channel i)
//   div_val  : packed divide values, channel i at [i*CNT_W +: CNT_W]
//   tick     : per-channel registered tick pulse
//   busy     : per-channel counting indicator
module div_frecventa_prog
  import div_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int DEFAULT_DIV = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       enable,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] div_val,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    div_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .enable  (enable[gi]),
      .mode    (mode[gi]),
      .start   (start[gi]),
      .load    (load[gi]),
      .div_val (div_val[gi*CNT_W +: CNT_W]),
      .tick    (tick[gi]),
      .busy    (busy[gi])
    );
  end

endmodule

// File: tb/tb_div_frecventa_prog.sv
// Self-checking bench for div_frecventa_prog: directed scenarios with
// explicit expected pulse positions, then randomized traffic, all compared
// against a cycle-level reference model based on elapsed-cycle arithmetic.
module tb_div_frecventa_prog;

  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 24;
  localparam int DEFAULT_DIV = 10;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_CH-1:0]       enable, mode, start, load;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       tick, busy;
  logic [CNT_W-1:0]        dv [NUM_CH];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_dv
    assign div_val[gi*CNT_W +: CNT_W] = dv[gi];
  end

  div_frecventa_prog #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .mode    (mode),
    .start   (start),
    .load    (load),
    .div_val (div_val),
    .tick    (tick),
    .busy    (busy)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a running channel counts elapsed cycles since it was
  // started (the starting edge is cycle 1); a tick is due whenever the elapsed
  // count is a multiple of the divide value. Loads and one-shot re-arms
  // restart the elapsed count without ticking.
  int               m_div [NUM_CH];
  int               m_el  [NUM_CH];
  bit               m_act [NUM_CH];
  bit               m_one [NUM_CH];
  logic [NUM_CH-1:0] m_tick, m_busy;

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        m_div[i] = DEFAULT_DIV;
        m_el[i]  = 0;
        m_act[i] = 1'b0;
        m_one[i] = 1'b0;
        m_tick[i] = 1'b0;
      end else begin
        m_tick[i] = 1'b0;
        if (load[i]) begin
          m_div[i] = (dv[i] == '0) ? 1 : int'(dv[i]);
          m_el[i]  = 1;
          if (!enable[i]) m_act[i] = 1'b0;
        end else if (!enable[i]) begin
          m_act[i] = 1'b0;
        end else if (!m_act[i]) begin
          if (mode[i] == 1'b0) begin
            m_act[i]  = 1'b1;
            m_one[i]  = 1'b0;
            m_el[i]   = 1;
            m_tick[i] = (m_el[i] % m_div[i] == 0);
          end else if (start[i]) begin
            m_el[i] = 1;
            if (m_div[i] == 1) begin
              m_tick[i] = 1'b1;
            end else begin
              m_act[i] = 1'b1;
              m_one[i] = 1'b1;
            end
          end
        end else if (m_one[i] && start[i]) begin
          m_el[i] = 1;
        end else begin
          m_el[i]++;
          if (m_el[i] % m_div[i] == 0) begin
            m_tick[i] = 1'b1;
            if (m_one[i]) m_act[i] = 1'b0;
          end
        end
      end
      m_busy[i] = m_act[i];
    end
  endtask

  // One clock: update the model with the inputs the DUT samples, then
  // compare shortly after the edge.
  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check("mdl_tick", 32'(tick), 32'(m_tick));
    check("mdl_busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle_inputs();
    enable = '0;
    mode   = '0;
    start  = '0;
    load   = '0;
    for (int i = 0; i < NUM_CH; i++) dv[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Periodic, default divide 10
    do_reset();
    enable[0] = 1'b1;
    for (int c = 0; c < 32; c++) begin
      step();
      check("per10_tick", 32'(tick[0]), 32'((c + 1) % 10 == 0));
      check("per10_busy", 32'(busy[0]), 32'd1);
    end
    $display("[TB] periodic div 10 on ch0 done");

    // Reload channel 1 with 3 while counting
    do_reset();
    enable[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      load[1] = (c == 5);
      dv[1]   = 24'd3;
      step();
      check("reload_tick", 32'(tick[1]), 32'((c + 1) >= 8 && ((c + 1 - 8) % 3 == 0)));
    end
    $display("[TB] reload ch1 to 3 done");

    // One-shot on channel 2, div 4, with and without a re-arm
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      mode[2]   = 1'b1;
      enable[2] = 1'b1;
      load[2]   = 1'b1;
      dv[2]     = 24'd4;
      step();
      load[2] = 1'b0;
      for (int c = 0; c < 12; c++) begin
        int k;
        k = c + 1;
        start[2] = (c == 2) || (pass == 1 && c == 4);
        step();
        if (pass == 0) begin
          check("oneshot_tick", 32'(tick[2]), 32'(k == 6));
          check("oneshot_busy", 32'(busy[2]), 32'(k >= 3 && k <= 5));
        end else begin
          check("rearm_tick", 32'(tick[2]), 32'(k == 8));
          check("rearm_busy", 32'(busy[2]), 32'(k >= 3 && k <= 7));
        end
      end
      start[2] = 1'b0;
      $display("[TB] one-shot ch2 pass %0d done", pass);
    end

    // Divide 0 stored as 1; loads coinciding with a due tick
    do_reset();
    enable[0] = 1'b1;
    enable[3] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      int k;
      logic exp3;
      k = c + 1;
      load[3] = (c == 3) || (c == 12);
      dv[3]   = (c == 12) ? 24'd2 : 24'd0;
      load[0] = (c == 9);
      dv[0]   = 24'd10;
      step();
      if (k < 5)       exp3 = 1'b0;
      else if (k <= 12) exp3 = 1'b1;
      else if (k == 13) exp3 = 1'b0;
      else             exp3 = (k % 2 == 0);
      check("div0_tick", 32'(tick[3]), 32'(exp3));
      check("loadwrap_tick", 32'(tick[0]), 32'(k == 19));
    end
    $display("[TB] zero divide and load-on-wrap done");

    // Enable drop at counter 7, re-enable later
    do_reset();
    for (int c = 0; c < 25; c++) begin
      int k;
      k = c + 1;
      enable[0] = !(c >= 8 && c <= 11);
      step();
      check("endrop_tick", 32'(tick[0]), 32'(k == 22));
      check("endrop_busy", 32'(busy[0]), 32'(k <= 8 || k >= 13));
    end
    $display("[TB] enable drop and re-enable done");

    // Reset mid-count on all channels with a load pending
    do_reset();
    enable = '1;
    for (int c = 0; c < 22; c++) begin
      int k;
      k = c + 1;
      rst  = (c == 9);
      load = (c == 9) ? '1 : '0;
      for (int i = 0; i < NUM_CH; i++) dv[i] = 24'd3;
      step();
      check("rstmid_tick", 32'(tick), (k == 20) ? 32'hF : 32'h0);
      check("rstmid_busy", 32'(busy), (k == 10) ? 32'h0 : 32'hF);
    end
    rst  = 1'b0;
    load = '0;
    $display("[TB] reset mid-count done");

    // Randomized traffic against the model
    do_reset();
    enable = '1;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(199) == 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(15) == 0) enable[i] = ~enable[i];
        if ($urandom_range(7) == 0)  mode[i]   = 1'($urandom);
        start[i] = ($urandom_range(5) == 0);
        load[i]  = ($urandom_range(19) == 0);
        dv[i]    = CNT_W'($urandom_range(6));
      end
      step();
    end
    $display("[TB] random traffic done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
